// File: rtl/lc3_pipe_controller.sv
// LC-3 pipeline sequencer: stage enables, data-memory state and flush control.
// Every output is registered, so a decision made from the inputs sampled on
// one rising edge becomes visible during the following cycle.
module lc3_pipe_controller #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] ir_exec,
  input  logic        br_taken,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        mem_timeout
);

  typedef enum logic [2:0] {
    S_FILL, S_RUN, S_MEM_RD, S_MEM_WR, S_MEM_IND, S_FLUSH
  } state_t;

  localparam logic [1:0] MS_RD   = 2'd0;
  localparam logic [1:0] MS_IND  = 2'd1;
  localparam logic [1:0] MS_WR   = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;

  // enable bundle order: fetch, updatePC, decode, execute, writeback
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_FPC  = 5'b11000;
  localparam logic [4:0] EN_NOWB = 5'b11110;
  localparam logic [4:0] EN_ALL  = 5'b11111;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);
  localparam logic [7:0] TMO_LIMIT  = 8'(MEM_TIMEOUT);
  localparam logic       TMO_EN     = (MEM_TIMEOUT != 0);

  state_t     state, state_n;
  logic [1:0] fill_cnt, fill_cnt_n;
  logic [2:0] flush_cnt, flush_cnt_n;
  logic [7:0] tmo_cnt, tmo_cnt_n;
  logic       served, served_n;
  logic       ind_wr, ind_wr_n;
  logic [4:0] en, en_n;
  logic [1:0] mem_state_n;
  logic       mem_timeout_n;

  logic [3:0] opcode;
  logic       op_rd, op_wr, op_ind, op_xfer;
  logic [7:0] tmo_inc;
  logic       timed_out;
  logic [2:0] flush_inc;
  logic       unused_ir;

  assign opcode    = ir_exec[15:12];
  assign unused_ir = ^ir_exec[11:0];
  assign op_rd     = (opcode == 4'b0010) || (opcode == 4'b0110);
  assign op_wr     = (opcode == 4'b0011) || (opcode == 4'b0111);
  assign op_ind    = (opcode == 4'b1010) || (opcode == 4'b1011);
  assign op_xfer   = (opcode == 4'b0000) || (opcode == 4'b1100);

  // The wait counter saturates so a disabled timeout can never wrap into a false hit.
  assign tmo_inc   = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
  assign timed_out = TMO_EN && (tmo_inc == TMO_LIMIT);
  assign flush_inc = flush_cnt + 3'd1;

  assign {enable_fetch, enable_updatePC, enable_decode,
          enable_execute, enable_writeback} = en;

  // Next-state and next-output decision for the sequencer.
  always_comb begin
    state_n       = state;
    fill_cnt_n    = fill_cnt;
    flush_cnt_n   = flush_cnt;
    tmo_cnt_n     = tmo_cnt;
    ind_wr_n      = ind_wr;
    en_n          = EN_NONE;
    mem_state_n   = MS_IDLE;
    mem_timeout_n = mem_timeout;
    // An instruction that has moved through execute releases the served lock.
    served_n      = en[1] ? 1'b0 : served;

    case (state)
      S_FILL: begin
        if (complete_instr) begin
          fill_cnt_n = fill_cnt + 2'd1;
          case (fill_cnt)
            2'd0: en_n = EN_FPC;
            2'd1: en_n = 5'b11100;
            2'd2: en_n = EN_NOWB;
            default: begin
              en_n    = EN_ALL;
              state_n = S_RUN;
            end
          endcase
        end
      end

      S_RUN: begin
        if (!served && (op_rd || op_wr || op_ind)) begin
          tmo_cnt_n = 8'd0;
          ind_wr_n  = opcode[0];
          if (op_ind) begin
            state_n     = S_MEM_IND;
            mem_state_n = MS_IND;
          end else if (op_rd) begin
            state_n     = S_MEM_RD;
            mem_state_n = MS_RD;
          end else begin
            state_n     = S_MEM_WR;
            mem_state_n = MS_WR;
          end
        end else if (br_taken && op_xfer) begin
          state_n     = S_FLUSH;
          flush_cnt_n = 3'd0;
          en_n        = EN_FPC;
        end else if (complete_instr) begin
          en_n = EN_ALL;
        end
      end

      S_MEM_IND, S_MEM_RD, S_MEM_WR: begin
        if (complete_data) begin
          tmo_cnt_n = 8'd0;
          if (state == S_MEM_IND) begin
            state_n     = ind_wr ? S_MEM_WR : S_MEM_RD;
            mem_state_n = ind_wr ? MS_WR : MS_RD;
          end else begin
            state_n  = S_RUN;
            served_n = 1'b1;
            en_n     = (state == S_MEM_RD) ? EN_ALL : EN_NOWB;
          end
        end else if (timed_out) begin
          // Abort the access: no data to write back, resume the pipeline.
          state_n       = S_RUN;
          served_n      = 1'b1;
          tmo_cnt_n     = 8'd0;
          mem_timeout_n = 1'b1;
          en_n          = EN_NOWB;
        end else begin
          tmo_cnt_n   = tmo_inc;
          mem_state_n = (state == S_MEM_IND) ? MS_IND :
                        (state == S_MEM_RD)  ? MS_RD  : MS_WR;
        end
      end

      S_FLUSH: begin
        if (complete_instr) begin
          flush_cnt_n = flush_inc;
          if (flush_inc == FLUSH_LAST) begin
            state_n = S_RUN;
            en_n    = EN_ALL;
          end else begin
            en_n = EN_FPC;
          end
        end
      end

      default: state_n = S_FILL;
    endcase
  end

  // State, counters and registered outputs; reset aborts any access or flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_FILL;
      fill_cnt    <= 2'd0;
      flush_cnt   <= 3'd0;
      tmo_cnt     <= 8'd0;
      served      <= 1'b0;
      ind_wr      <= 1'b0;
      en          <= EN_NONE;
      mem_state   <= MS_IDLE;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      fill_cnt    <= fill_cnt_n;
      flush_cnt   <= flush_cnt_n;
      tmo_cnt     <= tmo_cnt_n;
      served      <= served_n;
      ind_wr      <= ind_wr_n;
      en          <= en_n;
      mem_state   <= mem_state_n;
      mem_timeout <= mem_timeout_n;
    end
  end

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Scoreboard bench for lc3_pipe_controller: each driven cycle queues the
// output expected after the next rising edge; a monitor pops and compares.
module tb_lc3_pipe_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        complete_instr = 1'b1;
  logic        complete_data = 1'b0;
  logic [15:0] ir_exec = 16'h1021;
  logic        br_taken = 1'b0;
  logic        enable_fetch, enable_updatePC, enable_decode;
  logic        enable_execute, enable_writeback;
  logic [1:0]  mem_state;
  logic        mem_timeout;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  localparam logic [15:0] NOP = 16'h1021;
  localparam logic [4:0]  NONE = 5'b00000;
  localparam logic [4:0]  FPC  = 5'b11000;
  localparam logic [4:0]  NOWB = 5'b11110;
  localparam logic [4:0]  ALL  = 5'b11111;

  lc3_pipe_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clock(clock),
    .reset(reset),
    .complete_instr(complete_instr),
    .complete_data(complete_data),
    .ir_exec(ir_exec),
    .br_taken(br_taken),
    .enable_fetch(enable_fetch),
    .enable_updatePC(enable_updatePC),
    .enable_decode(enable_decode),
    .enable_execute(enable_execute),
    .enable_writeback(enable_writeback),
    .mem_state(mem_state),
    .mem_timeout(mem_timeout)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] ev(input logic [4:0] e, input logic [1:0] ms, input logic to);
    return {e, ms, to};
  endfunction

  function automatic logic [7:0] observed();
    return {enable_fetch, enable_updatePC, enable_decode, enable_execute,
            enable_writeback, mem_state, mem_timeout};
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b (FPDEW_ms_to)", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the output expected after the next edge.
  task automatic drive(input string tag, input logic ci, input logic cd,
                       input logic [15:0] ir, input logic bt, input logic [7:0] want);
    @(negedge clock);
    complete_instr = ci;
    complete_data  = cd;
    ir_exec        = ir;
    br_taken       = bt;
    exp_q.push_back(want);
    tag_q.push_back(tag);
  endtask

  // Compare registered outputs shortly after each active edge.
  always @(posedge clock) begin
    #2;
    if (exp_q.size() > 0) check_eq(tag_q.pop_front(), observed(), exp_q.pop_front());
  end

  initial begin
    #12;
    check_eq("reset_state", observed(), ev(NONE, 2'd3, 1'b0));
    @(posedge clock);
    #1 reset = 1'b1;

    // fill, with one stalled instruction fetch first
    drive("fill_stall", 1'b0, 1'b0, NOP, 1'b0, ev(NONE, 2'd3, 1'b0));
    drive("fill1", 1'b1, 1'b0, NOP, 1'b0, ev(FPC, 2'd3, 1'b0));
    drive("fill2", 1'b1, 1'b0, NOP, 1'b0, ev(5'b11100, 2'd3, 1'b0));
    drive("fill3", 1'b1, 1'b0, NOP, 1'b0, ev(NOWB, 2'd3, 1'b0));
    drive("fill4", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));
    drive("run", 1'b1, 1'b1, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));
    drive("run_istall", 1'b0, 1'b0, NOP, 1'b0, ev(NONE, 2'd3, 1'b0));
    drive("run_resume", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));

    // LD: three cycles in read state, then full resume with writeback
    drive("ld_enter", 1'b1, 1'b0, 16'h2A05, 1'b0, ev(NONE, 2'd0, 1'b0));
    drive("ld_wait1", 1'b1, 1'b0, 16'h2A05, 1'b0, ev(NONE, 2'd0, 1'b0));
    drive("ld_wait2", 1'b1, 1'b0, 16'h2A05, 1'b0, ev(NONE, 2'd0, 1'b0));
    drive("ld_done", 1'b1, 1'b1, 16'h2A05, 1'b0, ev(ALL, 2'd3, 1'b0));
    drive("ld_noretrig", 1'b1, 1'b0, 16'h2A05, 1'b0, ev(ALL, 2'd3, 1'b0));
    drive("ld_next", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));

    // LDI: indirect then read, served blocks re-entry
    drive("ldi_enter", 1'b1, 1'b0, 16'hA401, 1'b0, ev(NONE, 2'd1, 1'b0));
    drive("ldi_ind2", 1'b1, 1'b0, 16'hA401, 1'b0, ev(NONE, 2'd1, 1'b0));
    drive("ldi_rd1", 1'b1, 1'b1, 16'hA401, 1'b0, ev(NONE, 2'd0, 1'b0));
    drive("ldi_rd2", 1'b1, 1'b0, 16'hA401, 1'b0, ev(NONE, 2'd0, 1'b0));
    drive("ldi_done", 1'b1, 1'b1, 16'hA401, 1'b0, ev(ALL, 2'd3, 1'b0));
    drive("ldi_noretrig", 1'b1, 1'b0, 16'hA401, 1'b0, ev(ALL, 2'd3, 1'b0));
    drive("ldi_next", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));

    // STI with immediate completions: indirect -> write -> resume without writeback
    drive("sti_enter", 1'b1, 1'b1, 16'hB000, 1'b0, ev(NONE, 2'd1, 1'b0));
    drive("sti_wr", 1'b1, 1'b1, 16'hB000, 1'b0, ev(NONE, 2'd2, 1'b0));
    drive("sti_done", 1'b1, 1'b1, 16'hB000, 1'b0, ev(NOWB, 2'd3, 1'b0));
    drive("sti_next", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));

    // taken BR flushes two cycles; br_taken on ADD is ignored
    drive("br_f1", 1'b1, 1'b0, 16'h0E03, 1'b1, ev(FPC, 2'd3, 1'b0));
    drive("br_f2", 1'b1, 1'b0, NOP, 1'b0, ev(FPC, 2'd3, 1'b0));
    drive("br_run", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));
    drive("br_ignored", 1'b1, 1'b0, NOP, 1'b1, ev(ALL, 2'd3, 1'b0));

    // JMP flush frozen by a fetch stall; opcodes/br_taken ignored while flushing
    drive("jmp_f1", 1'b1, 1'b0, 16'hC1C0, 1'b1, ev(FPC, 2'd3, 1'b0));
    drive("jmp_frz", 1'b0, 1'b0, 16'h2A05, 1'b1, ev(NONE, 2'd3, 1'b0));
    drive("jmp_f2", 1'b1, 1'b0, 16'h2A05, 1'b1, ev(FPC, 2'd3, 1'b0));
    drive("jmp_run", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));

    // memory op with br_taken: memory wins, branch not re-sampled
    drive("mb_enter", 1'b1, 1'b0, 16'h6A05, 1'b1, ev(NONE, 2'd0, 1'b0));
    drive("mb_done", 1'b1, 1'b1, 16'h6A05, 1'b1, ev(ALL, 2'd3, 1'b0));
    drive("mb_nobr", 1'b1, 1'b0, 16'h6A05, 1'b1, ev(ALL, 2'd3, 1'b0));
    drive("mb_next", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));

    // ST with no completion: four write cycles then timeout, sticky flag
    drive("st_enter", 1'b1, 1'b0, 16'h3001, 1'b0, ev(NONE, 2'd2, 1'b0));
    for (int i = 0; i < 3; i++)
      drive("st_wait", 1'b1, 1'b0, 16'h3001, 1'b0, ev(NONE, 2'd2, 1'b0));
    drive("st_tmo", 1'b1, 1'b0, 16'h3001, 1'b0, ev(NOWB, 2'd3, 1'b1));
    drive("st_sticky", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b1));

    // reset asserted in the middle of a write access
    drive("wr2_enter", 1'b1, 1'b0, 16'h7001, 1'b0, ev(NONE, 2'd2, 1'b1));
    drive("wr2_wait", 1'b1, 1'b0, 16'h7001, 1'b0, ev(NONE, 2'd2, 1'b1));
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check_eq("async_reset", observed(), ev(NONE, 2'd3, 1'b0));
    ir_exec = NOP;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    drive("refill1", 1'b1, 1'b0, NOP, 1'b0, ev(FPC, 2'd3, 1'b0));
    drive("refill2", 1'b1, 1'b0, NOP, 1'b0, ev(5'b11100, 2'd3, 1'b0));
    drive("refill3", 1'b1, 1'b0, NOP, 1'b0, ev(NOWB, 2'd3, 1'b0));
    drive("refill4", 1'b1, 1'b0, NOP, 1'b0, ev(ALL, 2'd3, 1'b0));

    @(posedge clock);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_controller.md
Name: lc3_pipe_controller

Overview:
- Central sequencer for the LC-3 five-stage pipeline: fetch, decode, execute, writeback and PC update.
- Generates the per-stage enables, including the enable_decode that qualifies dout/npc_in at the decode input.
- Stalls the pipeline around data-memory accesses (including indirect loads/stores) and flushes it on taken control transfers.
- Sits beside the datapath; drives only stage enables and the data-memory state.

Parameters:
- FLUSH_CYCLES, 2: cycles decode/execute/writeback stay disabled after a taken branch/JMP (range 1–7).
- MEM_TIMEOUT, 255: max cycles to wait for complete_data per access before aborting; 0 disables timeout.

Ports:
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- complete_instr  in  1  instruction memory returned dout this cycle.
- complete_data  in  1  data memory finished current access.
- ir_exec  in  16  instruction currently held in execute stage (opcode = [15:12]).
- br_taken  in  1  execute stage resolved BR/JMP as taken this cycle.
- enable_fetch  out  1  fetch stage enable.
- enable_updatePC  out  1  PC register update enable.
- enable_decode  out  1  decode stage enable.
- enable_execute  out  1  execute stage enable.
- enable_writeback  out  1  writeback (register file write) enable.
- mem_state  out  2  0 = read, 1 = indirect read, 2 = write, 3 = idle.
- mem_timeout  out  1  sticky error; set on any memory timeout, cleared only by reset.

Behaviour:
- Reset (asynchronous, active-low):
  - All enables 0, mem_state = 3, mem_timeout = 0.
  - state = FILL, fill_cnt = 0, served = 0.
  - Reset asserted mid-access or mid-flush aborts immediately to these values.
- Outputs are registered; every decision below takes effect the cycle after the sampled condition.
- FILL (after reset release):
  - Cycle 1: fetch and updatePC.
  - Cycle 2: adds decode.
  - Cycle 3: adds execute.
  - Cycle 4: adds writeback, then enter RUN.
  - complete_instr = 0 holds fill_cnt and drives all enables 0 that cycle.
- RUN: all five enables 1, mem_state = 3. Evaluation priority each cycle:
  1. Memory op on ir_exec[15:12] with served = 0:
     - LD 0010 / LDR 0110 → MEM_RD.
     - ST 0011 / STR 0111 → MEM_WR.
     - LDI 1010 / STI 1011 → MEM_IND.
  2. br_taken = 1 with opcode BR 0000 or JMP 1100 → FLUSH. br_taken with any other opcode is ignored.
  3. complete_instr = 0 → all enables 0 this cycle; state stays RUN.
- served flag:
  - Set on exit from any memory state.
  - Cleared on any cycle enable_execute = 1, so the same ir_exec never retriggers.
- MEM_IND: mem_state = 1, all enables 0. On complete_data = 1, go to MEM_RD (LDI) or MEM_WR (STI) and reset the timeout counter.
- MEM_RD: mem_state = 0, all enables 0. On complete_data = 1, return to RUN; enable_writeback = 1 on the first RUN cycle together with the other enables.
- MEM_WR: mem_state = 2, all enables 0. On complete_data = 1, return to RUN; writeback 0 on the first RUN cycle.
- complete_data handling:
  - Sampled only in memory states; ignored elsewhere.
  - Asserted in the same cycle a memory state is entered, it completes that state (minimum 1 cycle per memory state).
- Timeout: per-state counter increments each cycle waiting. When it reaches MEM_TIMEOUT (if ≠ 0): set mem_timeout, return to RUN, mem_state = 3.
- FLUSH:
  - Lasts FLUSH_CYCLES cycles: fetch = 1, updatePC = 1, decode = 0, execute = 0, writeback = 0, then RUN.
  - br_taken and memory opcodes are ignored during FLUSH.
  - complete_instr = 0 freezes the flush counter with all enables 0.
- Simultaneous memory opcode and br_taken: memory wins; the branch is not re-sampled afterwards.
- Counter widths: fill 2 bits, flush 3 bits, timeout 8 bits (saturating).

Test Plan:
- Release reset with complete_instr = 1 → enables ramp {F,PC}, +D, +E, +W over 4 cycles; mem_state stays 3.
- RUN, ir_exec = 16'h2A05 (LD), complete_data after 3 cycles → mem_state = 0 for 3 cycles, all enables 0, then all 1 including writeback; no retrigger.
- ir_exec = 16'hA401 (LDI), complete_data pulses at cycles 2 and 4 → mem_state 1,1,0,0 then 3; served prevents second entry.
- ir_exec = 16'h0E03 (BR) with br_taken = 1 → 2 cycles of F = PC = 1, D = E = W = 0, then all 1.
- ir_exec = 16'h3001 (ST), complete_data never, MEM_TIMEOUT = 4 → after 4 cycles mem_timeout = 1 sticky, RUN resumes.
- Reset asserted low mid MEM_WR → enables 0 and mem_state = 3 asynchronously, refill after release.
